divu_hilo: RTL

Multicycle unsigned divider owning the HI/LO register pair. It executes DIVU (funct 6'b011011) issued from EX and holds the quotient in LO and the remainder in HI. The HiOut/LoOut register outputs feed the writeback result mux, which returns them for MFHI (6'b010000) and MFLO (6'b010010). The pipeline hazard unit stalls the pipeline on `busy`.

---
 rtl/divu_hilo.sv | 97 +++++++++
 1 files changed

// File: rtl/divu_hilo.sv
// Multicycle restoring unsigned divider owning HI (remainder) / LO (quotient).
// 32 edges accept->result; busy while running, new DIVU dropped while busy; done pulses one cycle.
module divu_hilo #(
  parameter int         WIDTH = 32,
  parameter logic [5:0] DIVU  = 6'b011011
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut,
  output logic             busy,
  output logic             done
);

  localparam int       CW   = $clog2(WIDTH);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_quot_nx;

  assign w_accept = valid && (Signal == DIVU) && (r_state == IDLE);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign w_rem_sh  = {r_rem, r_quot[WIDTH-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_div});
  assign w_diff    = w_rem_sh[WIDTH-1:0] - r_div;
  assign w_rem_nx  = w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
  assign w_quot_nx = {r_quot[WIDTH-2:0], w_ge};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_div   <= '0;
      r_rem   <= '0;
      r_quot  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_div   <= dataB;
            r_rem   <= '0;
            r_quot  <= dataA;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        default: begin
          r_rem  <= w_rem_nx;
          r_quot <= w_quot_nx;
          r_cnt  <= r_cnt + 1'b1;
          // HI/LO are only touched on the final step, so MFHI/MFLO never see partials.
          if (w_last) begin
            r_hi    <= w_rem_nx;
            r_lo    <= w_quot_nx;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

  assign HiOut = r_hi;
  assign LoOut = r_lo;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule
